// File: rtl/shared_res_sched_pkg.sv
// Shared definitions for the shared-resource scheduler.
//   sched_state_t : scheduler FSM states (IDLE, GRANT, GAP)
//   hold_width()  : width of the tenure hold counter for resource parameter p
//   idx_width()   : width of a requester index for n requesters
package shared_res_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_t;

   // Counter width follows the resource's cast-to-sum width.
   function automatic int hold_width(int p);
      return int'(p + 2);
   endfunction

   function automatic int idx_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_res_sched_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo N; reports the first set bit.
//   req   : per-requester request vector
//   ptr   : scan start position (always < N)
//   found : at least one request is set
//   idx   : index of the first set request at or after ptr
module rr_pick
   import shared_res_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand [N];
   logic [N-1:0]  hit;

   // cand[gi] is the requester visited gi steps after ptr.
   for (genvar gi = 0; gi < N; gi++) begin : g_off
      logic [IW:0] sum;
      assign sum      = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign hit[gi]  = |(req & (N'(1) << cand[gi]));
   end

   // Walk from the farthest offset down so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/shared_res_sched.sv
// Round-robin scheduler granting exclusive use of one shared resource to
// N requesters, one tenure at a time, each tenure bounded by a hold counter.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : per-requester level request
//   rel     : per-requester one-cycle release pulse
//   gnt     : one-hot grant (registered), usable as the resource mux select
//   gnt_idx : index of the current or most recent grantee (registered)
//   busy    : high while a tenure is in progress
//   expired : one-cycle pulse when a tenure is ended purely by timeout
module shared_res_sched
   import shared_res_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int P        = 1,
   localparam int W        = hold_width(P),
   localparam int MAX_HOLD = 2**W - 1,
   localparam int IW       = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  rel,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          busy,
   output logic          expired
);

   sched_state_t  state;
   logic [W-1:0]  hold_cnt;
   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_next;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          own_rel;
   logic          own_drop;
   logic          hold_max;
   logic          release_now;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // During GRANT, gnt is the one-hot of gnt_idx, so masking with it
   // selects the grantee's own rel/req bits; other bits are ignored.
   assign own_rel     = |(rel & gnt);
   assign own_drop    = ~|(req & gnt);
   assign hold_max    = (hold_cnt == W'(MAX_HOLD));
   assign release_now = own_rel | own_drop | hold_max;

   // Next scan starts just after the released grantee (stays 0 when N=1).
   assign ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         busy     <= 1'b0;
         expired  <= 1'b0;
         hold_cnt <= '0;
         ptr      <= '0;
      end else begin
         expired <= 1'b0;
         case (state)
            GRANT: begin
               if (release_now) begin
                  gnt     <= '0;
                  busy    <= 1'b0;
                  state   <= GAP;
                  ptr     <= ptr_next;
                  // Flag only tenures that ran out without a voluntary end.
                  expired <= hold_max & ~own_rel & ~own_drop;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               // IDLE and GAP arbitrate identically; GAP only guarantees
               // one low cycle of gnt between back-to-back tenures.
               if (pick_found) begin
                  gnt      <= N'(1) << pick_idx;
                  gnt_idx  <= pick_idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shared_res_sched.sv
// Self-checking bench for shared_res_sched (N=4, P=1).
module tb_shared_res_sched;

   localparam int N          = 4;
   localparam int P          = 1;
   localparam int IW         = 2;
   localparam int MAX_TENURE = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  rel;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          busy;
   logic          expired;

   int n_cmp;
   int n_err;

   // Reference model: who owns the resource, for how many cycles, and
   // where the next search starts.
   int m_owner;
   int m_tenure;
   int m_ptr;
   int m_last;
   bit m_exp;

   shared_res_sched #(
      .N (N),
      .P (P)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .expired (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_tenure = 0;
      m_ptr    = 0;
      m_last   = 0;
      m_exp    = 0;
   endtask

   task automatic model_edge();
      bit let_go;
      bit timed;
      int p;
      m_exp = 0;
      if (m_owner >= 0) begin
         let_go = rel[m_owner] || !req[m_owner];
         timed  = (m_tenure == MAX_TENURE);
         if (let_go || timed) begin
            m_exp   = timed && !let_go;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_tenure++;
         end
      end else begin
         p = model_pick(req, m_ptr);
         if (p >= 0) begin
            m_owner  = p;
            m_last   = p;
            m_tenure = 1;
         end
      end
   endtask

   function automatic logic [N+IW+1:0] model_outs();
      logic [N-1:0] g;
      g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      return {g, IW'(m_last), (m_owner >= 0), m_exp};
   endfunction

   // Advance one clock edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      rel   = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_cmp++;
         if ({gnt, gnt_idx, busy, expired} !== '0) begin
            n_err++;
            $display("FAIL reset_idle cycle %0d: gnt=%b idx=%0d busy=%b exp=%b, required all zero",
                     c, gnt, gnt_idx, busy, expired);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0101;
      tick();
      n_cmp++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_first cycle 1: gnt=%b idx=%0d busy=%b, required 0001/0/1", gnt, gnt_idx, busy);
      end
      tick();
      tick();
      rel = 4'b0001;
      tick();
      rel = '0;
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_idx !== 2'd0 || expired !== 1'b0) begin
         n_err++;
         $display("FAIL basic_gap cycle 4: gnt=%b idx=%0d busy=%b exp=%b, required 0000/0/0/0",
                  gnt, gnt_idx, busy, expired);
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_second cycle 5: gnt=%b idx=%0d busy=%b, required 0100/2/1", gnt, gnt_idx, busy);
      end
      req = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= MAX_TENURE; c++) begin
         tick();
         n_cmp++;
         if (gnt !== 4'b0010 || expired !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_hold cycle %0d: gnt=%b exp=%b, required 0010/0", c, gnt, expired);
         end
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || expired !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_expire cycle 9: gnt=%b exp=%b busy=%b, required 0000/1/0", gnt, expired, busy);
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || expired !== 1'b0 || gnt_idx !== 2'd1) begin
         n_err++;
         $display("FAIL timeout_regrant cycle 10: gnt=%b exp=%b idx=%0d, required 0010/0/1", gnt, expired, gnt_idx);
      end
      req = '0;
   endtask

   task automatic test_rel_at_max();
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= MAX_TENURE; c++) tick();
      n_cmp++;
      if (gnt !== 4'b0010) begin
         n_err++;
         $display("FAIL relmax_hold cycle 8: gnt=%b, required 0010", gnt);
      end
      rel = 4'b0010;
      tick();
      rel = '0;
      n_cmp++;
      if (gnt !== 4'b0000 || expired !== 1'b0) begin
         n_err++;
         $display("FAIL relmax_release cycle 9: gnt=%b exp=%b, required 0000/0", gnt, expired);
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      int want;
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         want = i % N;
         n_cmp++;
         if (gnt !== (N'(1) << want) || gnt_idx !== IW'(want)) begin
            n_err++;
            $display("FAIL b2b_grant %0d: gnt=%b idx=%0d, required idx %0d", i, gnt, gnt_idx, want);
         end
         tick();
         tick();
         rel = N'(1) << want;
         tick();
         rel = '0;
         n_cmp++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap %0d: gnt=%b busy=%b, required 0000/0", i, gnt, busy);
         end
         tick();
      end
      req = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
         n_err++;
         $display("FAIL areset_pre: gnt=%b idx=%0d, required 0100/2", gnt, gnt_idx);
      end
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({gnt, gnt_idx, busy, expired} !== '0) begin
         n_err++;
         $display("FAIL areset_clear: gnt=%b idx=%0d busy=%b exp=%b, required all zero",
                  gnt, gnt_idx, busy, expired);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1100;
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL areset_restart: gnt=%b idx=%0d busy=%b, required 0100/2/1", gnt, gnt_idx, busy);
      end
      req = '0;
   endtask

   task automatic test_random();
      logic [N+IW+1:0] exp_v;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         end
         rel = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         tick();
         exp_v = model_outs();
         n_cmp++;
         if ({gnt, gnt_idx, busy, expired} !== exp_v) begin
            n_err++;
            $display("FAIL random cycle %0d: gnt/idx/busy/exp=%b, required %b", c, {gnt, gnt_idx, busy, expired}, exp_v);
         end
      end
      req = '0;
      rel = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      req   = '0;
      rel   = '0;
      model_reset();
      test_reset();
      test_basic();
      test_timeout();
      test_rel_at_max();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shared_res_sched.md
Name: shared_res_sched

Overview:
- Round-robin scheduler that shares one parameterized constant-result resource, a P-configured submodule instance, among N requesters.
- Grants exclusive access one requester at a time and bounds each tenure with a hold counter.
- The hold counter width is the resource's cast-to-sum width, W = P+2.
- Sits between requester ports and the shared submodule instance at the top level. Drives a one-hot grant used as the output-mux select.

Parameters:
- N, 4, number of requesters (1..8).
- P, 1, resource parameter; also sets the counter width.
- W, P+2 (localparam, cast to int sum), hold counter width; 3 at default.
- MAX_HOLD, 2**W-1 (localparam), last permitted grant cycle index; 7 at default.
- IW, (N>1 ? $clog2(N) : 1) (localparam), grant index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester level request.
- rel  in  N  per-requester one-cycle release pulse.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IW  index of current or last grantee, registered.
- busy  out  1  high while in GRANT.
- expired  out  1  one-cycle pulse when a tenure is force-ended by timeout.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, gnt=0, gnt_idx=0, busy=0, expired=0, hold_cnt=0, ptr=0.
- States: IDLE, GRANT, GAP (enum in package).
- Arbitration (IDLE or GAP):
  - Pick the first set req bit scanning ptr, ptr+1, …, wrapping mod N.
  - If any is found: next cycle gnt=onehot(pick), gnt_idx=pick, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req to gnt is exactly 1 cycle.
  - No req: IDLE→IDLE; GAP→IDLE.
- GRANT: gnt held stable; hold_cnt increments by 1 each cycle. Release conditions, evaluated each cycle:
  - (a) rel[gnt_idx]=1;
  - (b) req[gnt_idx]=0;
  - (c) hold_cnt==MAX_HOLD.
- On any release, at the next edge:
  - gnt=0, busy=0, state=GAP;
  - ptr=(gnt_idx+1) mod N (N=1: ptr stays 0);
  - gnt_idx retains its value.
- expired=1 for exactly the release edge only when (c) holds and neither (a) nor (b) holds. If (a) or (b) coincides with (c), expired=0.
- Maximum tenure is 2**W cycles (8 at default). gnt is low for exactly 1 cycle (GAP) between back-to-back grants.
- hold_cnt never wraps. It is W bits wide, reset to 0 on grant, and compared for equality with MAX_HOLD.
- rel bits of non-granted requesters, and any rel while not in GRANT, are ignored.
- req changes on non-granted bits during GRANT have no effect until the next arbitration.
- rst_n low mid-tenure: all outputs clear immediately (asynchronously). After reset, arbitration restarts from ptr=0.

Decomposition:
- Package shared_res_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_t;
  - function hold_width(int p) returning int'(p+2);
  - function idx_width(int n).
- Sub-module rr_pick: combinational, params N and IW; inputs req and ptr; outputs found and idx.
- Main module: FSM, hold counter, pointer, output registers; one rr_pick instance.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, busy=0, gnt_idx=0, expired=0 throughout.
- req=4'b0101 from cycle 0 with default params -> gnt=4'b0001 at cycle 1; rel[0] pulsed at cycle 3 -> gnt=0 at cycle 4 (GAP); gnt=4'b0100 at cycle 5, gnt_idx=2.
- req=4'b0010 held, no rel -> gnt=4'b0010 for cycles 1..8 (8 cycles); expired=1 at cycle 9 with gnt=0; regrant 4'b0010 at cycle 10.
- Same as previous, but rel[1] pulsed on the cycle where hold_cnt==7 -> release at the next edge, expired stays 0.
- req=4'b1111 held, each grantee pulses rel 2 cycles after its grant -> grant order idx 0,1,2,3,0, with gnt low exactly 1 cycle between grants.
- Grant idx 2 active, rst_n driven low mid-cycle -> gnt=0 and busy=0 immediately, without waiting for a clock edge; after release, req=4'b1100 -> gnt=4'b0100 (ptr reset to 0).
